instr_fetch_queue: RTL and testbench

- Producer side of the instruction interface consumed by the control unit and decoder.
- Generates the fetch PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents them to decode over a valid/ready handshake; a redirect input (taken branch or jump) flushes all speculative work.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_fetch_queue.sv | 104 ++++++++++
 tb/tb_instr_fetch_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_FETCH,
      S_FULL,
      S_FLUSH
   } fetch_state_t;

   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_INSTR_W   = 32;
   localparam int PC_STEP       = 4;
   localparam int PC_ALIGN_BITS = 2;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]  pc;
      logic [DEF_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush has priority over push.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t,
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  entry_t        entry_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [CW-1:0] count_o,
   output entry_t        head_o
);

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   // Storage is not reset; count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push_i && count_q == CW'(DEPTH)));
         assert (!(pop_i && count_q == '0));
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC generation, credit-based instruction memory requests and redirect
// kill logic in front of a small queue feeding decode.
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    DEPTH       = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req_o,
   output logic [ADDR_WIDTH-1:0]  imem_addr_o,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
   input  logic                   redirect_i,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [INSTR_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0]  pc_o,
   output logic [ADDR_WIDTH-1:0]  pcplus4_o
);

   localparam int                    CW    = $clog2(DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(PC_STEP);
   localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'((1 << PC_ALIGN_BITS) - 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  pc;
      logic [INSTR_WIDTH-1:0] instr;
   } entry_t;

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] req_pc_q;
   logic                  inflight_q;
   logic [CW-1:0]         count, count_d;
   logic                  credit, kill, push, pop;
   entry_t                head, push_entry;

   // Credit uses registered state only, so ready/redirect never reach the request.
   assign credit = (count + CW'(inflight_q)) < CW'(DEPTH);
   // The response landing in the cycle after a redirect belongs to the old path.
   assign kill   = (state_q == S_FLUSH);
   assign push   = !rst && inflight_q && !kill;
   assign pop    = valid_o && ready_i;

   assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count + CW'(push) - CW'(pop);
      if (credit) fetch_pc_d = fetch_pc_q + STEP;
      if (redirect_i) begin
         state_d    = S_FLUSH;
         count_d    = '0;
         fetch_pc_d = redirect_pc_i & AMASK;
      end else if (state_q == S_FLUSH) begin
         state_d = S_FETCH;
      end else if ((count_d + CW'(credit)) >= CW'(DEPTH)) begin
         state_d = S_FULL;
      end else begin
         state_d = S_FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         req_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= credit;
         req_pc_q   <= fetch_pc_q;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .entry_i (push_entry),
      .pop_i   (pop),
      .flush_i (redirect_i),
      .count_o (count),
      .head_o  (head)
   );

   assign imem_req_o  = !rst && credit;
   assign imem_addr_o = rst ? '0 : fetch_pc_q;
   assign valid_o     = !rst && (count != '0);
   assign instr_o     = rst ? '0 : head.instr;
   assign pc_o        = rst ? '0 : head.pc;
   assign pcplus4_o   = rst ? '0 : head.pc + STEP;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1, ready = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_pc = '0, rdata = '0;
   logic        req, valid;
   logic [31:0] addr, instr, pc, pcp4;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   instr_fetch_queue #(
      .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req_o(req), .imem_addr_o(addr), .imem_rdata_i(rdata),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .valid_o(valid), .ready_i(ready),
      .instr_o(instr), .pc_o(pc), .pcplus4_o(pcp4)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h13 + (a >> 2);
   endfunction

   // Synchronous instruction memory, one-cycle latency.
   always @(posedge clk) rdata <= mem_word(addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of fetched entries plus one in-flight slot.
   logic [31:0] m_pc = RESET_PC;
   logic [31:0] q_pc[$];
   logic [31:0] q_in[$];
   logic        m_inf = 1'b0, m_kill = 1'b0, m_req;
   logic [31:0] m_inf_pc = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = RESET_PC;
         q_pc.delete();
         q_in.delete();
         m_inf = 1'b0;
         m_kill = 1'b0;
      end else begin
         m_req = (q_pc.size() + int'(m_inf)) < DEPTH;
         if (q_pc.size() != 0 && ready) begin
            void'(q_pc.pop_front());
            void'(q_in.pop_front());
         end
         if (m_inf && !m_kill) begin
            q_pc.push_back(m_inf_pc);
            q_in.push_back(mem_word(m_inf_pc));
         end
         if (redirect) begin
            q_pc.delete();
            q_in.delete();
         end
         m_kill   = redirect;
         m_inf    = m_req;
         m_inf_pc = m_pc;
         if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
         else if (m_req) m_pc = m_pc + 32'd4;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_req", 32'(req), 32'd0);
         chk("rst_addr", addr, 32'd0);
         chk("rst_valid", 32'(valid), 32'd0);
         chk("rst_pc", pc, 32'd0);
         chk("rst_instr", instr, 32'd0);
         chk("rst_pcplus4", pcp4, 32'd0);
      end else begin
         chk("req", 32'(req), 32'((q_pc.size() + int'(m_inf)) < DEPTH));
         chk("addr", addr, m_pc);
         chk("valid", 32'(valid), 32'(q_pc.size() != 0));
         if (q_pc.size() != 0) begin
            chk("pc", pc, q_pc[0]);
            chk("instr", instr, q_in[0]);
            chk("pcplus4", pcp4, q_pc[0] + 32'd4);
         end
      end
   end

   task automatic drive(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      rst = r; ready = rdy; redirect = rd; redirect_pc = rpc;
      @(negedge clk);
      #1;
   endtask

   initial begin
      int          nreq, nstale, got;
      logic [31:0] first;
      logic [31:0] popped[$];

      // Reset and first fetch latency, then streaming with ready held.
      drive(1, 0, 0, 0); drive(1, 0, 0, 0);
      chk("reset_req", 32'(req), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      drive(0, 1, 0, 0);
      chk("c0_req", 32'(req), 32'd1);
      chk("c0_addr", addr, 32'h0);
      drive(0, 1, 0, 0);
      chk("c1_valid", 32'(valid), 32'd0);
      for (int k = 2; k < 10; k++) begin
         drive(0, 1, 0, 0);
         chk("stream_valid", 32'(valid), 32'd1);
         chk("stream_pc", pc, 32'(4 * (k - 2)));
         if (k == 2) begin
            chk("c2_instr", instr, 32'h0000_0013);
            chk("c2_pcplus4", pcp4, 32'h4);
         end
      end

      // Backpressure: credit stops requests at DEPTH, then drain in order.
      drive(1, 0, 0, 0); drive(1, 0, 0, 0);
      nreq = 0;
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 0, 0);
         if (req) nreq++;
      end
      chk("full_nreq", 32'(nreq), 32'd4);
      chk("full_req_off", 32'(req), 32'd0);
      chk("full_head", pc, 32'h0);
      popped.delete();
      first = '1;
      got = 0;
      for (int k = 0; k < 8; k++) begin
         drive(0, 1, 0, 0);
         if (valid) popped.push_back(pc);
         if (req && got == 0) begin
            first = addr;
            got = 1;
         end
      end
      chk("resume_addr", first, 32'h10);
      for (int i = 0; i < 5; i++)
         chk("drain_pc", (popped.size() > i) ? popped[i] : 32'hDEAD_BEEF, 32'(4 * i));

      // Redirect with two entries queued and one in flight.
      drive(1, 0, 0, 0); drive(1, 0, 0, 0);
      drive(0, 0, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
      drive(0, 0, 1, 32'h0000_0103);
      drive(0, 0, 0, 0);
      chk("redir_req", 32'(req), 32'd1);
      chk("redir_addr", addr, 32'h100);
      chk("redir_flush_valid", 32'(valid), 32'd0);
      drive(0, 0, 0, 0);
      chk("redir_gap_valid", 32'(valid), 32'd0);
      drive(0, 0, 0, 0);
      chk("redir_valid", 32'(valid), 32'd1);
      chk("redir_pc", pc, 32'h100);
      chk("redir_instr", instr, 32'h53);

      // Redirect in the same cycle as an accepted handshake at 0x8.
      drive(1, 0, 0, 0); drive(1, 0, 0, 0);
      for (int k = 0; k < 4; k++) drive(0, 1, 0, 0);
      drive(0, 1, 1, 32'h200);
      chk("hs_redir_valid", 32'(valid), 32'd1);
      chk("hs_redir_pc", pc, 32'h8);
      nstale = 0;
      first = '1;
      got = 0;
      for (int k = 0; k < 6; k++) begin
         drive(0, 1, 0, 0);
         if (valid) begin
            if (got == 0) begin
               first = pc;
               got = 1;
            end
            if (pc == 32'h8 || pc == 32'hC) nstale++;
         end
      end
      chk("hs_redir_first", first, 32'h200);
      chk("hs_redir_stale", 32'(nstale), 32'd0);

      // Address wrap at the top of memory.
      drive(0, 1, 1, 32'hFFFF_FFFC);
      drive(0, 1, 0, 0);
      chk("wrap_addr0", addr, 32'hFFFF_FFFC);
      drive(0, 1, 0, 0);
      chk("wrap_addr1", addr, 32'h0);
      drive(0, 1, 0, 0);
      chk("wrap_pc0", pc, 32'hFFFF_FFFC);
      chk("wrap_pcplus4", pcp4, 32'h0);
      chk("wrap_instr", instr, 32'h4000_0012);
      drive(0, 1, 0, 0);
      chk("wrap_pc1", pc, 32'h0);
      chk("wrap_pcplus4_1", pcp4, 32'h4);

      // Reset mid-stream.
      drive(0, 1, 0, 0);
      drive(1, 1, 0, 0);
      chk("mid_rst_addr", addr, 32'h0);
      chk("mid_rst_valid", 32'(valid), 32'd0);
      chk("mid_rst_pc", pc, 32'h0);
      drive(1, 1, 0, 0);
      drive(0, 1, 0, 0);
      chk("post_rst_req", 32'(req), 32'd1);
      chk("post_rst_addr", addr, RESET_PC);
      chk("post_rst_valid", 32'(valid), 32'd0);

      // Randomized traffic with varying backpressure.
      for (int blk = 0; blk < 15; blk++) begin
         int thr;
         thr = $urandom_range(10, 95);
         for (int k = 0; k < 200; k++) begin
            drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < thr) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                  $urandom);
         end
      end
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
